// File: rtl/csa_resolver_if.sv
// Handshake bundle between a carry-save producer and the resolver/consumer pair.
// The master drives the input pair and output acceptance; the slave is the resolver.
interface csa_resolver_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_cout;

    modport master (
        output in_valid, in_sum, in_carry, out_ready,
        input  in_ready, out_valid, out_result, out_cout
    );

    modport slave (
        input  in_valid, in_sum, in_carry, out_ready,
        output in_ready, out_valid, out_result, out_cout
    );
endinterface

// File: rtl/csa_resolver.sv
// Multi-cycle carry-propagate adder turning a carry-save pair into a binary word,
// resolving CHUNK bits per cycle with valid/ready handshakes on both sides.
module csa_resolver #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic              clk,
    input  logic              rst,
    csa_resolver_if.slave     bus
);
    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] cv_q, cv_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic             out_cout_q, out_cout_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic [CHUNK-1:0] chunk_s;
    logic [CHUNK-1:0] chunk_c;
    logic [CHUNK:0]   chunk_add;
    logic             last_chunk;

    // Select the operand chunk addressed by the current index
    always_comb begin
        chunk_s = '0;
        chunk_c = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (idx_q == IDX_W'(k)) begin
                chunk_s = sum_q[k*CHUNK +: CHUNK];
                chunk_c = cv_q[k*CHUNK +: CHUNK];
            end
        end
        chunk_add  = (CHUNK+1)'(chunk_s) + (CHUNK+1)'(chunk_c) + (CHUNK+1)'(carry_q);
        last_chunk = (idx_q == IDX_W'(N - 1));
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        sum_d        = sum_q;
        cv_d         = cv_q;
        res_d        = res_q;
        out_result_d = out_result_q;
        out_cout_d   = out_cout_q;
        out_valid_d  = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    sum_d   = bus.in_sum;
                    cv_d    = bus.in_carry;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                carry_d = chunk_add[CHUNK];
                for (int unsigned k = 0; k < N; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        res_d[k*CHUNK +: CHUNK] = chunk_add[CHUNK-1:0];
                    end
                end
                if (last_chunk) begin
                    out_result_d = res_d;
                    out_cout_d   = chunk_add[CHUNK];
                    out_valid_d  = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            sum_q        <= '0;
            cv_q         <= '0;
            res_q        <= '0;
            out_result_q <= '0;
            out_cout_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            carry_q      <= carry_d;
            sum_q        <= sum_d;
            cv_q         <= cv_d;
            res_q        <= res_d;
            out_result_q <= out_result_d;
            out_cout_q   <= out_cout_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_cout   = out_cout_q;
endmodule

// File: tb/tb_csa_resolver.sv
// Bench for csa_resolver: a CHUNK=8 and a CHUNK=32 instance, directed vectors,
// corner sequences and a randomized CSA3T2 stream against an arithmetic model.
module tb_csa_resolver;
    localparam int unsigned W      = 32;
    localparam int          NUM    = 40;
    localparam int          BUDGET = 20000;

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] cv;
        logic [W-1:0] res;
        logic         cout;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid_v  [2];
    logic [W-1:0] in_sum_v    [2];
    logic [W-1:0] in_carry_v  [2];
    logic         out_ready_v [2];
    logic         in_ready_v  [2];
    logic         out_valid_v [2];
    logic [W-1:0] out_result_v[2];
    logic         out_cout_v  [2];

    csa_resolver_if #(.WIDTH(W)) bus8 ();
    csa_resolver_if #(.WIDTH(W)) bus32 ();

    csa_resolver #(.WIDTH(W), .CHUNK(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    csa_resolver #(.WIDTH(W), .CHUNK(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    assign bus8.in_valid   = in_valid_v[0];
    assign bus8.in_sum     = in_sum_v[0];
    assign bus8.in_carry   = in_carry_v[0];
    assign bus8.out_ready  = out_ready_v[0];
    assign in_ready_v[0]   = bus8.in_ready;
    assign out_valid_v[0]  = bus8.out_valid;
    assign out_result_v[0] = bus8.out_result;
    assign out_cout_v[0]   = bus8.out_cout;

    assign bus32.in_valid  = in_valid_v[1];
    assign bus32.in_sum    = in_sum_v[1];
    assign bus32.in_carry  = in_carry_v[1];
    assign bus32.out_ready = out_ready_v[1];
    assign in_ready_v[1]   = bus32.in_ready;
    assign out_valid_v[1]  = bus32.out_valid;
    assign out_result_v[1] = bus32.out_result;
    assign out_cout_v[1]   = bus32.out_cout;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transaction with out_ready held high; checks result, cout and latency
    task automatic run_pair(input int d, input vec_t v, input int exp_lat);
        int lat;
        @(negedge clk);
        in_valid_v[d]  = 1'b1;
        in_sum_v[d]    = v.s;
        in_carry_v[d]  = v.cv;
        out_ready_v[d] = 1'b1;
        chk($sformatf("in_ready_idle[%0d]", d), 64'(in_ready_v[d]), 64'd1);
        @(posedge clk); #1;
        in_valid_v[d] = 1'b0;
        lat = 0;
        while (!out_valid_v[d] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency[%0d]", d), 64'(lat), 64'(exp_lat));
        chk($sformatf("result[%0d]", d), 64'(out_result_v[d]), 64'(v.res));
        chk($sformatf("cout[%0d]", d), 64'(out_cout_v[d]), 64'(v.cout));
        @(posedge clk); #1;
        chk($sformatf("valid_drop[%0d]", d), 64'(out_valid_v[d]), 64'd0);
        chk($sformatf("ready_back[%0d]", d), 64'(in_ready_v[d]), 64'd1);
    endtask

    vec_t tbl[7];
    exp_t q0[$];
    exp_t q1[$];

    initial begin
        int   sent[2];
        int   recv[2];
        logic acc[2];
        int   cyc;
        int   lat;

        tbl[0] = '{32'h0000_0004, 32'h0000_000E, 32'h0000_0012, 1'b0};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b1};
        tbl[2] = '{32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000, 1'b0};
        tbl[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1};
        tbl[6] = '{32'h1234_5678, 32'h1111_1110, 32'h2345_6788, 1'b0};

        for (int d = 0; d < 2; d++) begin
            in_valid_v[d] = 1'b0; in_sum_v[d] = '0; in_carry_v[d] = '0; out_ready_v[d] = 1'b0;
            sent[d] = 0; recv[d] = 0; acc[d] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_out_valid[%0d]", d), 64'(out_valid_v[d]), 64'd0);
            chk($sformatf("rst_out_result[%0d]", d), 64'(out_result_v[d]), 64'd0);
            chk($sformatf("rst_out_cout[%0d]", d), 64'(out_cout_v[d]), 64'd0);
            chk($sformatf("rst_in_ready[%0d]", d), 64'(in_ready_v[d]), 64'd1);
        end

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 7; i++)
                run_pair(d, tbl[i], (d == 0) ? 4 : 1);

        // Backpressure: result must hold, busy inputs ignored
        @(negedge clk);
        in_valid_v[0] = 1'b1; in_sum_v[0] = 32'hFFFF_FFFF; in_carry_v[0] = 32'h2; out_ready_v[0] = 1'b0;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        lat = 0;
        while (!out_valid_v[0] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", 64'(lat), 64'd4);
        in_valid_v[0] = 1'b1; in_sum_v[0] = 32'h5555_5555; in_carry_v[0] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 64'(out_valid_v[0]), 64'd1);
            chk("bp_result", 64'(out_result_v[0]), 64'h1);
            chk("bp_cout", 64'(out_cout_v[0]), 64'd1);
            chk("bp_in_ready", 64'(in_ready_v[0]), 64'd0);
            @(posedge clk); #1;
        end
        in_valid_v[0] = 1'b0; out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 64'(out_valid_v[0]), 64'd0);
        chk("bp_release_ready", 64'(in_ready_v[0]), 64'd1);
        chk("bp_result_held", 64'(out_result_v[0]), 64'h1);

        // Reset while RUN is at chunk index 2
        @(negedge clk);
        in_valid_v[0] = 1'b1; in_sum_v[0] = 32'h1234_5678; in_carry_v[0] = 32'h1111_1110;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", 64'(out_valid_v[0]), 64'd0);
        chk("midrst_ready", 64'(in_ready_v[0]), 64'd1);
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid_v[0]) lat++;
        end
        chk("midrst_no_stale_result", 64'(lat), 64'd0);
        run_pair(0, '{32'h1, 32'h2, 32'h3, 1'b0}, 4);

        // Randomized CSA3T2 stream on both builds with random backpressure
        cyc = 0;
        while ((recv[0] < NUM || recv[1] < NUM) && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (acc[d]) begin
                    in_valid_v[d] = 1'b0;
                    acc[d] = 1'b0;
                end
                if (!in_valid_v[d] && sent[d] < NUM && $urandom_range(3) != 0) begin
                    logic [W-1:0] a, b, c;
                    a = $urandom; b = $urandom; c = $urandom;
                    in_sum_v[d]   = a ^ b ^ c;
                    in_carry_v[d] = ((a & b) | (a & c) | (b & c)) << 1;
                    in_valid_v[d] = 1'b1;
                end
                out_ready_v[d] = 1'($urandom_range(1));
                if (in_valid_v[d] && in_ready_v[d]) begin
                    exp_t e;
                    logic [63:0] wide;
                    wide   = 64'(in_sum_v[d]) + 64'(in_carry_v[d]);
                    e.res  = in_sum_v[d] + in_carry_v[d];
                    e.cout = wide[32];
                    if (d == 0) q0.push_back(e); else q1.push_back(e);
                    sent[d]++;
                    acc[d] = 1'b1;
                end
                if (out_valid_v[d] && out_ready_v[d]) begin
                    exp_t e;
                    int   qn;
                    qn = (d == 0) ? q0.size() : q1.size();
                    if (qn == 0) begin
                        chk($sformatf("rnd_spurious[%0d]", d), 64'd1, 64'd0);
                    end else begin
                        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                        chk($sformatf("rnd_result[%0d]", d), 64'(out_result_v[d]), 64'(e.res));
                        chk($sformatf("rnd_cout[%0d]", d), 64'(out_cout_v[d]), 64'(e.cout));
                    end
                    recv[d]++;
                end
            end
        end
        chk("rnd_timeout", 64'(cyc >= BUDGET), 64'd0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rnd_sent[%0d]", d), 64'(sent[d]), 64'(NUM));
            chk($sformatf("rnd_recv[%0d]", d), 64'(recv[d]), 64'(NUM));
        end
        chk("rnd_q0_empty", 64'(q0.size()), 64'd0);
        chk("rnd_q1_empty", 64'(q1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
